// File: rtl/image_pkg.sv
// Shared definitions for the 28x28 image store and its clients.
// Holds the image geometry, word/address widths and the (x,y) -> word address
// mapping used by the drawing-grid controller and the VGA scan logic.
package image_pkg;

    localparam int unsigned GRID_SIZE  = 28;
    localparam int unsigned DEPTH      = GRID_SIZE * GRID_SIZE;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 16;
    // Width needed to index the storage array once an address is known to be in range.
    localparam int unsigned IDX_WIDTH  = $clog2(DEPTH);

    // Row-major pixel address: y*GRID_SIZE + x.
    function automatic logic [ADDR_WIDTH-1:0] pixel_addr(
        input logic [ADDR_WIDTH-1:0] x,
        input logic [ADDR_WIDTH-1:0] y
    );
        return y * ADDR_WIDTH'(GRID_SIZE) + x;
    endfunction

endpackage

// File: rtl/image_memory.sv
// 28x28 image store: DEPTH words of DATA_WIDTH-bit signed data, one write and
// one read port, both always ready.
//
// Ports:
//   clk          - single clock, all state changes on its rising edge
//   resetn       - asynchronous active-low reset (clears valid bits, zeroes data_out)
//   clear        - synchronous clear of the whole image, wins over a same-cycle write
//   write_addr   - word address for writes; addresses >= DEPTH are ignored
//   data_in      - signed write data
//   write_enable - write strobe
//   read_addr    - word address for reads; addresses >= DEPTH read as 0
//   data_out     - registered read data, 1-cycle latency, read-first on collisions
//
// The data array carries no reset so it can map onto block RAM; a per-word
// valid vector in flops makes unwritten or cleared words read as 0.
module image_memory
    import image_pkg::*;
(
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         clear,
    input  logic        [ADDR_WIDTH-1:0] write_addr,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         write_enable,
    input  logic        [ADDR_WIDTH-1:0] read_addr,
    output logic signed [DATA_WIDTH-1:0] data_out
);

    localparam logic [ADDR_WIDTH-1:0] DepthAddr = ADDR_WIDTH'(DEPTH);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DEPTH-1:0]             valid_d, valid_q;
    logic                         rd_hit_d, rd_hit_q;
    logic signed [DATA_WIDTH-1:0] rd_word_q;

    logic                         wr_in_range, rd_in_range;
    logic [IDX_WIDTH-1:0]         wr_idx, rd_idx;
    logic                         wr_ok;

    // Range checks use the full address so upper bits are never silently dropped.
    always_comb begin
        wr_in_range = (write_addr < DepthAddr);
        rd_in_range = (read_addr < DepthAddr);
        wr_idx      = wr_in_range ? write_addr[IDX_WIDTH-1:0] : '0;
        rd_idx      = rd_in_range ? read_addr[IDX_WIDTH-1:0] : '0;
        wr_ok       = write_enable & ~clear & wr_in_range;
    end

    always_comb begin
        valid_d = valid_q;
        if (clear) begin
            valid_d = '0;
        end else if (wr_ok) begin
            valid_d[wr_idx] = 1'b1;
        end
        // valid_q is the pre-write value, giving read-first behaviour.
        rd_hit_d = rd_in_range & ~clear & valid_q[rd_idx];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q  <= '0;
            rd_hit_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            rd_hit_q <= rd_hit_d;
        end
    end

    // RAM-style array: synchronous write, synchronous read of the old contents.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= data_in;
        end
        rd_word_q <= mem[rd_idx];
    end

    // Gating by the reset-able hit flag zeroes the output immediately on reset.
    assign data_out = rd_hit_q ? rd_word_q : '0;

endmodule

// File: tb/tb_image_memory.sv
module tb_image_memory;
    import image_pkg::*;

    logic                         clk;
    logic                         resetn;
    logic                         clear;
    logic        [ADDR_WIDTH-1:0] write_addr;
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         write_enable;
    logic        [ADDR_WIDTH-1:0] read_addr;
    logic signed [DATA_WIDTH-1:0] data_out;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference image: only written words exist; everything else reads 0.
    logic signed [DATA_WIDTH-1:0] model [int];

    image_memory dut (
        .clk          (clk),
        .resetn       (resetn),
        .clear        (clear),
        .write_addr   (write_addr),
        .data_in      (data_in),
        .write_enable (write_enable),
        .read_addr    (read_addr),
        .data_out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [DATA_WIDTH-1:0] lookup(input int a);
        if (a < int'(DEPTH) && model.exists(a)) return model[a];
        return '0;
    endfunction

    task automatic check(input string tag, input logic signed [DATA_WIDTH-1:0] exp);
        n_assert++;
        assert (data_out === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, data_out, exp);
        end
    endtask

    // One clock cycle: apply inputs, predict the read from the pre-edge image,
    // update the image, then sample 1 time unit after the edge.
    task automatic tick(input logic we, input logic [ADDR_WIDTH-1:0] wa,
                        input logic signed [DATA_WIDTH-1:0] d,
                        input logic [ADDR_WIDTH-1:0] ra, input logic clr,
                        input string tag);
        logic signed [DATA_WIDTH-1:0] exp;
        write_enable = we;
        write_addr   = wa;
        data_in      = d;
        read_addr    = ra;
        clear        = clr;
        exp = clr ? '0 : lookup(int'(ra));
        if (clr) model.delete();
        else if (we && int'(wa) < int'(DEPTH)) model[int'(wa)] = d;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    function automatic logic [ADDR_WIDTH-1:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return ADDR_WIDTH'($urandom_range(784, 65535));
            1, 2:    return ADDR_WIDTH'($urandom_range(770, 783));
            default: return ADDR_WIDTH'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        resetn       = 1'b0;
        clear        = 1'b0;
        write_enable = 1'b0;
        write_addr   = '0;
        data_in      = '0;
        read_addr    = '0;

        // Reset held
        #1;
        check("rst_t0", '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_held", '0);
        @(negedge clk);
        resetn = 1'b1;

        tick(1'b0, 16'd0, 0, 16'd0,   1'b0, "rst_rd0");
        tick(1'b0, 16'd0, 0, 16'd27,  1'b0, "rst_rd27");
        tick(1'b0, 16'd0, 0, 16'd783, 1'b0, "rst_rd783");

        // Write / read
        tick(1'b1, pixel_addr(16'd5, 16'd3), 1, 16'd0, 1'b0, "wr89");
        tick(1'b0, 16'd0, 0, 16'd89,  1'b0, "rd89");
        tick(1'b0, 16'd0, 0, 16'd90,  1'b0, "rd90");
        tick(1'b1, 16'd783, -7, 16'd0, 1'b0, "wr783");
        tick(1'b0, 16'd0, 0, 16'd783, 1'b0, "rd783");
        n_assert++;
        assert (data_out === 32'shFFFFFFF9) else begin
            n_fail++;
            $error("FAIL rd783_neg: observed %h expected %h", data_out, 32'hFFFFFFF9);
        end

        // Read during write, same address
        tick(1'b1, 16'd100, 42, 16'd100, 1'b0, "rdw_old");
        tick(1'b0, 16'd0, 0, 16'd100, 1'b0, "rdw_new");

        // Out of range
        tick(1'b1, 16'd0, 77, 16'd0, 1'b0, "wr0");
        tick(1'b1, 16'd784, 5, 16'd0, 1'b0, "oor_wr784");
        tick(1'b1, 16'hFFFF, 5, 16'd0, 1'b0, "oor_wrffff");
        tick(1'b0, 16'd0, 0, 16'd784, 1'b0, "oor_rd784");
        tick(1'b0, 16'd0, 0, 16'hFFFF, 1'b0, "oor_rdffff");
        tick(1'b0, 16'd0, 0, 16'd0, 1'b0, "oor_rd0");
        tick(1'b0, 16'd0, 0, 16'd16, 1'b0, "oor_rd16");

        // Clear with a simultaneous write
        tick(1'b1, 16'd10, 9, 16'd0, 1'b0, "clr_wr10");
        tick(1'b1, 16'd11, 9, 16'd10, 1'b0, "clr_wr11");
        tick(1'b1, 16'd12, 3, 16'd11, 1'b1, "clr_edge");
        tick(1'b0, 16'd0, 0, 16'd10, 1'b0, "clr_rd10");
        tick(1'b0, 16'd0, 0, 16'd11, 1'b0, "clr_rd11");
        tick(1'b0, 16'd0, 0, 16'd12, 1'b0, "clr_rd12");

        // Zero is a legal value; continuous writes are idempotent
        tick(1'b1, 16'd20, 0, 16'd20, 1'b0, "wr_zero");
        tick(1'b1, 16'd21, 123, 16'd20, 1'b0, "cont0");
        tick(1'b1, 16'd21, 123, 16'd21, 1'b0, "cont1");
        tick(1'b1, 16'd21, 123, 16'd21, 1'b0, "cont2");

        // Async reset mid-stream
        tick(1'b1, 16'd50, 1, 16'd0, 1'b0, "ar_wr50");
        tick(1'b0, 16'd0, 0, 16'd50, 1'b0, "ar_rd50");
        write_enable = 1'b1;
        write_addr   = 16'd50;
        data_in      = 32'sd5;
        @(negedge clk);
        resetn = 1'b0;
        model.delete();
        #1;
        check("ar_async", '0);
        @(posedge clk);
        #1;
        check("ar_held", '0);
        @(negedge clk);
        resetn = 1'b1;
        tick(1'b0, 16'd0, 0, 16'd50, 1'b0, "ar_rd50_after");

        // Randomised traffic against the reference image
        for (int i = 0; i < 800; i++) begin
            tick(1'(($urandom_range(0, 2)) != 0), rand_addr(), $urandom(), rand_addr(),
                 1'($urandom_range(0, 39) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "timeout");
    end

endmodule
